// File: rtl/enc_codeword_gen_16bit.sv
// Streaming extended-Hamming (16,11) SECDED encoder with a two-register pipeline,
// full backpressure and an optional per-word error-injection XOR mask.
module enc_codeword_gen_16bit #(
  parameter int CNT_W     = 16,
  parameter int INJECT_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [10:0]      data_in,
  input  logic [15:0]      inj_mask,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [15:0]      codeword_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] word_cnt,
  output logic             busy
);

  logic        s1_valid;
  logic [10:0] s1_data;
  logic [15:0] s1_mask;
  logic        s2_valid;
  logic        load1;
  logic        load2;
  logic [15:0] enc_word;
  logic [15:0] eff_mask;

  // Parity columns follow the decoder's parity-check matrix; c11 closes overall parity.
  function automatic logic [15:0] encode(input logic [10:0] d);
    logic p15, p14, p13, p12, p11;
    p15 = d[0] ^ d[2] ^ d[4] ^ d[6] ^ d[7] ^ d[9] ^ d[10];
    p14 = d[0] ^ d[1] ^ d[4] ^ d[5] ^ d[7] ^ d[8] ^ d[10];
    p13 = d[0] ^ d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9];
    p12 = d[0] ^ d[1] ^ d[2] ^ d[3] ^ d[4] ^ d[5] ^ d[6];
    p11 = (^d) ^ p12 ^ p13 ^ p14 ^ p15;
    return {p15, p14, p13, p12, p11, d};
  endfunction

  assign in_ready  = ~s1_valid | ~s2_valid | out_ready;
  assign load1     = in_valid & in_ready;
  assign load2     = s1_valid & (~s2_valid | out_ready);
  assign out_valid = s2_valid;
  assign busy      = s1_valid | s2_valid;
  assign enc_word  = encode(s1_data);
  assign eff_mask  = (INJECT_EN != 0) ? s1_mask : 16'h0000;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_mask  <= '0;
    end else begin
      if (load1) begin
        s1_valid <= 1'b1;
        s1_data  <= data_in;
        s1_mask  <= inj_mask;
      end else if (load2) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Stage 2 holds its word until downstream takes it; a refill may overlap the drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid     <= 1'b0;
      codeword_out <= 16'h0000;
    end else begin
      if (load2) begin
        s2_valid     <= 1'b1;
        codeword_out <= enc_word ^ eff_mask;
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt <= '0;
    end else if (s2_valid & out_ready) begin
      word_cnt <= word_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_enc_codeword_gen_16bit.sv
// Directed bench for enc_codeword_gen_16bit: default instance plus a second one
// with injection disabled and a 4-bit counter, both on the same stimulus.
module tb_enc_codeword_gen_16bit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] data_in = '0;
  logic [15:0] inj_mask = '0;
  logic        in_valid = 1'b0;
  logic        or_man = 1'b0;
  logic        rnd_or = 1'b0;
  logic        rnd_val = 1'b1;
  logic        out_ready;

  logic        in_ready, out_valid, busy;
  logic [15:0] codeword_out;
  logic [15:0] word_cnt;
  logic        in_ready_b, out_valid_b, busy_b;
  logic [15:0] codeword_b;
  logic [3:0]  word_cnt_b;

  int total = 0;
  int bad = 0;
  logic [15:0] got_q[$];
  logic [15:0] got_b[$];

  assign out_ready = rnd_or ? rnd_val : or_man;

  always #5 clk = ~clk;

  enc_codeword_gen_16bit dut (
    .clk(clk), .rst(rst), .data_in(data_in), .inj_mask(inj_mask),
    .in_valid(in_valid), .in_ready(in_ready), .codeword_out(codeword_out),
    .out_valid(out_valid), .out_ready(out_ready), .word_cnt(word_cnt), .busy(busy)
  );

  enc_codeword_gen_16bit #(.CNT_W(4), .INJECT_EN(0)) dut_b (
    .clk(clk), .rst(rst), .data_in(data_in), .inj_mask(inj_mask),
    .in_valid(in_valid), .in_ready(in_ready_b), .codeword_out(codeword_b),
    .out_valid(out_valid_b), .out_ready(out_ready), .word_cnt(word_cnt_b), .busy(busy_b)
  );

  always @(posedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) got_q.push_back(codeword_out);
      if (out_valid_b && out_ready) got_b.push_back(codeword_b);
    end
  end

  always @(posedge clk) begin
    if (rnd_or) begin
      #1;
      rnd_val = ($urandom_range(3) != 0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    idle(2);
    rst = 1'b0;
    got_q.delete();
    got_b.delete();
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [10:0] d, input logic [15:0] m);
    int n = 0;
    data_in = d;
    inj_mask = m;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("in_ready_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  function automatic logic [4:0] syndrome(input logic [15:0] c);
    logic [4:0] s;
    s[0] = c[15] ^ c[0] ^ c[2] ^ c[4] ^ c[6] ^ c[7] ^ c[9] ^ c[10];
    s[1] = c[14] ^ c[0] ^ c[1] ^ c[4] ^ c[5] ^ c[7] ^ c[8] ^ c[10];
    s[2] = c[13] ^ c[0] ^ c[1] ^ c[2] ^ c[3] ^ c[7] ^ c[8] ^ c[9];
    s[3] = c[12] ^ c[0] ^ c[1] ^ c[2] ^ c[3] ^ c[4] ^ c[5] ^ c[6];
    s[4] = ^c;
    return s;
  endfunction

  initial begin
    int nerr;
    logic [15:0] hold_cw;

    // reset state
    do_reset();
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_cw", 32'(codeword_out), 32'h0000);
    chk("rst_cnt", 32'(word_cnt), 32'd0);
    @(posedge clk); #1;

    // back-to-back stream
    or_man = 1'b1;
    send(11'h000, 16'h0);
    send(11'h001, 16'h0);
    send(11'h002, 16'h0);
    send(11'h7FF, 16'h0);
    idle(4);
    chk("b2b_count", 32'(got_q.size()), 32'd4);
    if (got_q.size() == 4) begin
      chk("b2b_w0", 32'(got_q[0]), 32'h0000);
      chk("b2b_w1", 32'(got_q[1]), 32'hF801);
      chk("b2b_w2", 32'(got_q[2]), 32'h7002);
      chk("b2b_w3", 32'(got_q[3]), 32'hFFFF);
    end
    chk("b2b_cnt", 32'(word_cnt), 32'd4);

    // latency and injection
    do_reset();
    send(11'h001, 16'h0004);
    @(negedge clk);
    chk("lat_ov_early", 32'(out_valid), 32'd0);
    chk("lat_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("lat_ov", 32'(out_valid), 32'd1);
    chk("inj1_cw", 32'(codeword_out), 32'hF805);
    chk("inj1_cw_off", 32'(codeword_b), 32'hF801);
    chk("inj1_parity", 32'(^codeword_out), 32'd1);
    @(posedge clk); #1;
    send(11'h001, 16'h0006);
    idle(4);
    chk("inj2_count", 32'(got_q.size()), 32'd2);
    if (got_q.size() == 2) chk("inj2_cw", 32'(got_q[1]), 32'hF807);
    if (got_b.size() == 2) chk("inj2_cw_off", 32'(got_b[1]), 32'hF801);
    else chk("inj2_count_off", 32'(got_b.size()), 32'd2);

    // backpressure
    do_reset();
    or_man = 1'b0;
    send(11'h004, 16'h0);
    send(11'h008, 16'h0);
    data_in = 11'h010;
    inj_mask = 16'h0;
    in_valid = 1'b1;
    @(negedge clk);
    chk("stall_ready", 32'(in_ready), 32'd0);
    hold_cw = codeword_out;
    repeat (3) @(negedge clk);
    chk("stall_ready_hold", 32'(in_ready), 32'd0);
    chk("stall_ov", 32'(out_valid), 32'd1);
    chk("stall_cw", 32'(codeword_out), 32'hB004);
    chk("stall_cw_stable", 32'(codeword_out), 32'(hold_cw));
    @(posedge clk); #1;
    or_man = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    idle(4);
    chk("stall_count", 32'(got_q.size()), 32'd3);
    if (got_q.size() == 3) begin
      chk("stall_w0", 32'(got_q[0]), 32'hB004);
      chk("stall_w1", 32'(got_q[1]), 32'h3808);
      chk("stall_w2", 32'(got_q[2]), 32'hD010);
    end

    // reset with two words buffered
    do_reset();
    or_man = 1'b1;
    send(11'h001, 16'h0);
    send(11'h002, 16'h0);
    idle(3);
    or_man = 1'b0;
    send(11'h004, 16'h0);
    send(11'h008, 16'h0);
    @(negedge clk);
    chk("prerst_busy", 32'(busy), 32'd1);
    chk("prerst_cnt", 32'(word_cnt), 32'd2);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    got_q.delete();
    @(negedge clk);
    chk("midrst_ov", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_busy_b", 32'(busy_b), 32'd0);
    chk("midrst_cnt", 32'(word_cnt), 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd1);
    chk("midrst_ready_b", 32'(in_ready_b), 32'd1);
    @(posedge clk); #1;
    or_man = 1'b1;
    idle(5);
    chk("midrst_stale", 32'(got_q.size()), 32'd0);

    // counter wrap on the 4-bit instance
    do_reset();
    or_man = 1'b1;
    for (int i = 0; i < 16; i++) send(11'(i), 16'h0);
    idle(3);
    chk("wrap_cnt_b16", 32'(word_cnt_b), 32'd0);
    chk("wrap_cnt16", 32'(word_cnt), 32'd16);
    send(11'h010, 16'h0);
    idle(3);
    chk("wrap_cnt_b17", 32'(word_cnt_b), 32'd1);
    chk("wrap_cnt17", 32'(word_cnt), 32'd17);

    // full data sweep with random gaps and random backpressure
    do_reset();
    rnd_or = 1'b1;
    for (int i = 0; i < 2048; i++) begin
      if ($urandom_range(3) == 0) idle($urandom_range(3, 1));
      send(11'(i), 16'h0);
    end
    rnd_or = 1'b0;
    or_man = 1'b1;
    idle(6);
    chk("sweep_count", 32'(got_q.size()), 32'd2048);
    nerr = 0;
    for (int i = 0; i < got_q.size() && i < 2048; i++) begin
      if (got_q[i][10:0] != 11'(i) || syndrome(got_q[i]) != 5'b00000) nerr++;
    end
    chk("sweep_bad_words", 32'(nerr), 32'd0);
    chk("sweep_cnt", 32'(word_cnt), 32'd2048);
    chk("sweep_cnt_b", 32'(word_cnt_b), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/enc_codeword_gen_16bit.md
Name: enc_codeword_gen_16bit

Overview:
Streaming extended-Hamming (16,11) SECDED encoder. It is the transmit-side counterpart of the 16-bit decoder syndrome path. It accepts 11-bit data words over a valid/ready handshake and produces 16-bit codewords through a 2-stage pipeline with full backpressure. An optional per-word error-injection mask is carried with each word so the bench and the system can drive the decoder with controlled 1- and 2-bit errors.

Parameters:
CNT_W, 16, width of the encoded-word counter.
INJECT_EN, 1, 1 = apply inj_mask at stage 2; 0 = inj_mask is ignored (forced to zero).

Ports:
clk  in  1  single clock; all logic is rising-edge.
rst  in  1  synchronous reset, active-high.
data_in  in  11  information bits d[10:0].
inj_mask  in  16  error-injection XOR mask, sampled together with data_in.
in_valid  in  1  data_in/inj_mask are valid.
in_ready  out  1  encoder can accept a word this cycle.
codeword_out  out  16  encoded word, after injection.
out_valid  out  1  codeword_out is valid.
out_ready  in  1  downstream accepts codeword_out.
word_cnt  out  CNT_W  number of codewords accepted downstream since reset.
busy  out  1  at least one pipeline stage holds a word.

Behaviour:
- Reset is synchronous and active-high, with single clock clk. While rst=1 at a rising edge, all state clears:
  - s1_valid=0, s2_valid=0, out_valid=0
  - codeword_out=16'h0000, word_cnt=0, busy=0
  - in_ready=1 from the first cycle after reset.
- Reset mid-operation discards in-flight words. No output handshake completes on a reset cycle, and word_cnt does not count it.
- Codeword bit mapping, matching the decoder parity-check matrix:
  - c[10:0] = d[10:0]
  - c15 = d0^d2^d4^d6^d7^d9^d10
  - c14 = d0^d1^d4^d5^d7^d8^d10
  - c13 = d0^d1^d2^d3^d7^d8^d9
  - c12 = d0^d1^d2^d3^d4^d5^d6
  - c11 = XOR of d[10:0], c12, c13, c14 and c15, so the XOR of all 16 bits is 0.
- Stage 1 (register): on an accept (in_valid & in_ready) it latches data_in and inj_mask and sets s1_valid.
- Stage 2 (register): codeword_out = encode(s1_data) ^ (INJECT_EN ? s1_mask : 0). out_valid = s2_valid.
- Pipeline advance rules:
  - stage 2 loads when s1_valid & (~s2_valid | out_ready)
  - stage 1 loads when in_valid & in_ready
  - in_ready = ~s1_valid | ~s2_valid | out_ready (combinational; no combinational path from in_valid)
  - simultaneous load and drain in the same cycle is legal at both stages.
- Latency is 2 cycles from accept to out_valid. Throughput is 1 word/cycle when out_ready is held at 1.
- Backpressure hold: while out_valid=1 and out_ready=0, codeword_out and out_valid stay stable. At most 2 words are buffered, and in_ready drops after the second word is accepted.
- A stalled word is never dropped or duplicated, and ordering is strictly FIFO.
- word_cnt increments on each out_valid & out_ready and wraps from 2^CNT_W-1 to 0 without a flag.
- busy = s1_valid | s2_valid.
- An inj_mask with 1 set bit gives a single-error word (odd overall parity). An inj_mask with 2 set bits gives a double-error word. inj_mask=0 gives a clean codeword.

Test Plan:
1. Reset, then send data 11'h000, 11'h001, 11'h002, 11'h7FF back-to-back with out_ready=1 -> after 2 cycles, codewords 16'h0000, 16'hF801, 16'h7002, 16'hFFFF arrive on consecutive cycles; word_cnt=4.
2. Drive all 2048 data values with random gaps -> every codeword has XOR of all bits = 0, and the decoder syndrome equals 5'b00000 for each.
3. Hold out_ready=0 and offer 3 words -> only 2 are accepted, in_ready=0 on the third; codeword_out is stable. Release out_ready -> words arrive in order, none lost.
4. Send data 11'h001 with inj_mask 16'h0004 -> codeword_out 16'hF805. Send the same data with inj_mask 16'h0006 -> 16'hF807. With INJECT_EN=0 -> 16'hF801 in both cases.
5. Assert rst while 2 words are buffered -> next cycle out_valid=0, busy=0, word_cnt=0, in_ready=1; no stale word appears later.
6. CNT_W=4, stream 17 words -> word_cnt reads 0 after the 16th word and 1 after the 17th.
